// File: rtl/frame_source_scheduler.sv
// Raster scheduler that pulls pixels from one of two sources per frame
// and emits them with line/frame strobes and an underflow counter.
module frame_source_scheduler #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 600,
    parameter int H_TOTAL  = 840,
    parameter int V_TOTAL  = 640
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        sel,
    input  logic        src0_valid,
    input  logic        src1_valid,
    input  logic [7:0]  src0_pixel,
    input  logic [7:0]  src1_pixel,
    output logic        src0_ready,
    output logic        src1_ready,
    output logic [7:0]  pixelout,
    output logic        pixelout_valid,
    output logic        frame_start,
    output logic        line_start,
    output logic        grant,
    output logic [15:0] underflow_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_HBLANK,
        S_VBLANK
    } state_t;

    localparam logic [9:0] L_HA  = 10'(H_ACTIVE);
    localparam logic [9:0] L_VA  = 10'(V_ACTIVE);
    localparam logic [9:0] L_HT1 = 10'(H_TOTAL - 1);
    localparam logic [9:0] L_VT1 = 10'(V_TOTAL - 1);

    state_t      r_state;
    state_t      w_state_nx;
    logic [9:0]  r_col;
    logic [9:0]  r_row;
    logic        r_grant;
    logic        r_fresh;
    logic [7:0]  r_pix;
    logic        r_pix_vld;
    logic        r_fs;
    logic        r_ls;
    logic [15:0] r_uf;

    logic [9:0]  w_col_nx;
    logic [9:0]  w_row_nx;
    logic        w_gvalid;
    logic [7:0]  w_gpix;
    logic        w_xfer;
    logic        w_adv;
    logic        w_lwrap;
    logic        w_fwrap;
    logic        w_ls_d;
    logic        w_fs_d;

    always_comb begin
        w_gvalid = r_grant ? src1_valid : src0_valid;
        w_gpix   = r_grant ? src1_pixel : src0_pixel;
        w_xfer   = (r_state == S_ACTIVE) && w_gvalid;
        w_adv    = w_xfer || (r_state == S_HBLANK) || (r_state == S_VBLANK);
        w_lwrap  = w_adv && (r_col == L_HT1);
        w_fwrap  = w_lwrap && (r_row == L_VT1);
        w_col_nx = r_col;
        w_row_nx = r_row;
        if (r_state == S_IDLE) begin
            w_col_nx = '0;
            w_row_nx = '0;
        end else if (w_lwrap) begin
            w_col_nx = '0;
            w_row_nx = w_fwrap ? 10'd0 : r_row + 10'd1;
        end else if (w_adv) begin
            w_col_nx = r_col + 10'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // A stopped run only takes effect at the frame boundary
    always_comb begin
        w_state_nx = r_state;
        if (r_state == S_IDLE) begin
            w_state_nx = run ? S_ACTIVE : S_IDLE;
        end else if (w_fwrap && !run) begin
            w_state_nx = S_IDLE;
        end else if (w_row_nx >= L_VA) begin
            w_state_nx = S_VBLANK;
        end else if (w_col_nx >= L_HA) begin
            w_state_nx = S_HBLANK;
        end else begin
            w_state_nx = S_ACTIVE;
        end
    end

    always_comb begin
        src0_ready = (r_state == S_ACTIVE) && !r_grant;
        src1_ready = (r_state == S_ACTIVE) && r_grant;
        w_ls_d     = (r_state == S_ACTIVE) && r_fresh && (r_col == 10'd0);
        w_fs_d     = w_ls_d && (r_row == 10'd0);
    end

    // r_fresh marks the first cycle a position is presented, so stalls
    // at col 0 do not repeat the strobes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_col     <= '0;
            r_row     <= '0;
            r_grant   <= 1'b0;
            r_fresh   <= 1'b0;
            r_pix     <= '0;
            r_pix_vld <= 1'b0;
            r_fs      <= 1'b0;
            r_ls      <= 1'b0;
            r_uf      <= '0;
        end else begin
            r_col     <= w_col_nx;
            r_row     <= w_row_nx;
            if (((r_state == S_IDLE) && run) || w_fwrap) begin
                r_grant <= sel;
            end
            r_fresh   <= (r_state == S_IDLE) ? run : w_adv;
            r_pix     <= w_xfer ? w_gpix : 8'd0;
            r_pix_vld <= w_xfer;
            r_fs      <= w_fs_d;
            r_ls      <= w_ls_d;
            if ((r_state == S_ACTIVE) && !w_gvalid && (r_uf != 16'hFFFF)) begin
                r_uf <= r_uf + 16'd1;
            end
        end
    end

    assign pixelout        = r_pix;
    assign pixelout_valid  = r_pix_vld;
    assign frame_start     = r_fs;
    assign line_start      = r_ls;
    assign grant           = r_grant;
    assign underflow_count = r_uf;

endmodule

// File: tb/tb_frame_source_scheduler.sv
// Bench for frame_source_scheduler on a shrunken raster: cycle model
// plus pixel scoreboard, segment table and hand-built corner sequences.
module tb_frame_source_scheduler;

    localparam int HA = 8;
    localparam int VA = 4;
    localparam int HT = 12;
    localparam int VT = 6;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        sel = 1'b0;
    logic        v0 = 1'b0;
    logic        v1 = 1'b0;
    logic [7:0]  p0 = 8'd0;
    logic [7:0]  p1 = 8'd0;
    logic        src0_ready;
    logic        src1_ready;
    logic [7:0]  pixelout;
    logic        pixelout_valid;
    logic        frame_start;
    logic        line_start;
    logic        grant;
    logic [15:0] underflow_count;

    frame_source_scheduler #(
        .H_ACTIVE(HA),
        .V_ACTIVE(VA),
        .H_TOTAL (HT),
        .V_TOTAL (VT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .run            (run),
        .sel            (sel),
        .src0_valid     (v0),
        .src1_valid     (v1),
        .src0_pixel     (p0),
        .src1_pixel     (p1),
        .src0_ready     (src0_ready),
        .src1_ready     (src1_ready),
        .pixelout       (pixelout),
        .pixelout_valid (pixelout_valid),
        .frame_start    (frame_start),
        .line_start     (line_start),
        .grant          (grant),
        .underflow_count(underflow_count)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    logic [7:0] q[$];

    int m_col = 0;
    int m_row = 0;
    int m_uf = 0;
    bit m_on = 0;
    bit m_grant = 0;
    bit m_fresh = 0;
    int xfer_seen = 0;
    bit fs_seen = 0;

    typedef struct {
        bit run;
        bit sel;
        bit v0;
        bit v1;
        int cycles;
        int exp_xfer;
        int exp_uf;
    } seg_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_on = 0;
        m_col = 0;
        m_row = 0;
        m_grant = 0;
        m_fresh = 0;
        m_uf = 0;
        q.delete();
    endtask

    task automatic step();
        bit act;
        bit v;
        bit ex_pv;
        bit ex_ls;
        bit ex_fs;
        logic [7:0] pix;
        act = m_on && (m_col < HA) && (m_row < VA);
        chk("src0_ready", src0_ready, act && !m_grant);
        chk("src1_ready", src1_ready, act && m_grant);
        chk("grant", grant, m_grant);
        ex_ls = act && m_fresh && (m_col == 0);
        ex_fs = ex_ls && (m_row == 0);
        ex_pv = 0;
        if (!m_on) begin
            if (run) begin
                m_on = 1;
                m_col = 0;
                m_row = 0;
                m_grant = sel;
                m_fresh = 1;
            end else begin
                m_fresh = 0;
            end
        end else begin
            v = m_grant ? v1 : v0;
            pix = m_grant ? p1 : p0;
            if (act && v) begin
                ex_pv = 1;
                q.push_back(pix);
            end
            if (act && !v && m_uf < 65535) m_uf++;
            m_fresh = !act || v;
            if (m_fresh) begin
                m_col++;
                if (m_col == HT) begin
                    m_col = 0;
                    m_row++;
                    if (m_row == VT) begin
                        m_row = 0;
                        m_grant = sel;
                        if (!run) m_on = 0;
                    end
                end
            end
        end
        @(posedge clock);
        #1;
        chk("pixelout_valid", pixelout_valid, ex_pv);
        if (pixelout_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pixel_unexpected: got %0h expected none", pixelout);
            end else begin
                chk("pixelout", pixelout, q.pop_front());
            end
        end else begin
            chk("pixelout_zero", pixelout, 0);
        end
        chk("line_start", line_start, ex_ls);
        chk("frame_start", frame_start, ex_fs);
        chk("underflow_count", underflow_count, m_uf);
        if (pixelout_valid) xfer_seen++;
        fs_seen = frame_start;
        p0 = 8'($urandom);
        p1 = 8'($urandom);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_src0_ready"}, src0_ready, 0);
        chk({tag, "_src1_ready"}, src1_ready, 0);
        chk({tag, "_pixelout"}, pixelout, 0);
        chk({tag, "_pixelout_valid"}, pixelout_valid, 0);
        chk({tag, "_frame_start"}, frame_start, 0);
        chk({tag, "_line_start"}, line_start, 0);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_underflow"}, underflow_count, 0);
    endtask

    initial begin
        seg_t segs[5];
        int xs;
        int cnt;
        int stalls;
        segs[0] = '{1, 0, 1, 0, 73, 32, 0};
        segs[1] = '{1, 1, 0, 1, 10, 0, 10};
        segs[2] = '{1, 1, 1, 1, 72, 32, 10};
        segs[3] = '{0, 0, 0, 1, 72, 32, 10};
        segs[4] = '{0, 0, 1, 1, 5, 0, 10};

        #1 reset = 1'b0;
        #11;
        chk_all_zero("por");
        @(negedge clock);
        reset = 1'b1;
        model_reset();

        for (int i = 0; i < 5; i++) begin
            run = segs[i].run;
            sel = segs[i].sel;
            v0 = segs[i].v0;
            v1 = segs[i].v1;
            xs = xfer_seen;
            repeat (segs[i].cycles) step();
            chk($sformatf("seg%0d_xfers", i), xfer_seen - xs, segs[i].exp_xfer);
            chk($sformatf("seg%0d_underflow", i), underflow_count, segs[i].exp_uf);
        end

        run = 1;
        sel = 0;
        v0 = 1;
        v1 = 0;
        cnt = 0;
        while (cnt < 10 && !fs_seen) begin
            step();
            cnt++;
        end
        chk("restart_fs_latency", cnt, 2);
        cnt = 0;
        stalls = 0;
        fs_seen = 0;
        while (cnt < 200) begin
            v0 = !(m_on && m_row == 1 && m_col == 3 && stalls < 5);
            if (!v0) stalls++;
            step();
            cnt++;
            if (fs_seen) break;
        end
        v0 = 1;
        chk("stalled_frame_len", cnt, HT * VT + 5);
        chk("stall_underflow", underflow_count, 15);

        cnt = 0;
        while (cnt < 100 && m_row != 2) begin
            step();
            cnt++;
        end
        chk("reach_row2", m_row, 2);
        #2 reset = 1'b0;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        @(posedge clock);
        @(negedge clock);
        chk_all_zero("held_rst");
        reset = 1'b1;
        cnt = 0;
        fs_seen = 0;
        while (cnt < 10 && !fs_seen) begin
            step();
            cnt++;
        end
        chk("post_reset_fs_latency", cnt, 2);

        v0 = 0;
        repeat (65540) step();
        chk("underflow_saturated", underflow_count, 16'hFFFF);
        chk("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
